// File: rtl/harness_sdiv_14s_6s_14_seq_1.sv
// Sequential signed divider, 14-bit dividend by 6-bit divisor, one restoring
// iteration per enabled clock; sign handling is done on magnitudes around the core.
module harness_sdiv_14s_6s_14_seq_1 #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 14,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 14
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout_quot,
  output logic [din1_WIDTH-1:0] dout_rem,
  output logic                  div_by_zero
);

  // ID is an instance tag only; folding it in with a zero weight keeps it referenced.
  localparam int LAST = NUM_STAGE - 1 + 0 * ID;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state;
  logic [din0_WIDTH-1:0]   work;   // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [din1_WIDTH-1:0]   dsr;
  logic [din1_WIDTH:0]     prem;
  logic [3:0]              cnt;
  logic                    sgn0;
  logic                    sgn1;
  logic                    zdiv;

  logic [din1_WIDTH+1:0]   shifted;
  logic [din1_WIDTH+1:0]   diff;
  logic                    qbit;
  logic [din1_WIDTH:0]     prem_nx;
  logic [din0_WIDTH-1:0]   qmag;
  logic [din0_WIDTH-1:0]   qsgn;
  logic [din1_WIDTH-1:0]   rmag;
  logic [din1_WIDTH-1:0]   rsgn;

  always_comb begin
    shifted = {prem, work[din0_WIDTH-1]};
    diff    = shifted - {2'b00, dsr};
    qbit    = ~diff[din1_WIDTH+1];
    prem_nx = qbit ? diff[din1_WIDTH:0] : shifted[din1_WIDTH:0];
    qmag    = {work[din0_WIDTH-2:0], qbit};
    // Negating a zero magnitude yields zero, so +0 falls out without a special case.
    qsgn    = (sgn0 ^ sgn1) ? -qmag : qmag;
    rmag    = prem_nx[din1_WIDTH-1:0];
    rsgn    = sgn0 ? -rmag : rmag;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      work        <= '0;
      dsr         <= '0;
      prem        <= '0;
      cnt         <= '0;
      sgn0        <= 1'b0;
      sgn1        <= 1'b0;
      zdiv        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dout_quot   <= '0;
      dout_rem    <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work  <= din0[din0_WIDTH-1] ? -din0 : din0;
            dsr   <= din1[din1_WIDTH-1] ? -din1 : din1;
            sgn0  <= din0[din0_WIDTH-1];
            sgn1  <= din1[din1_WIDTH-1];
            zdiv  <= (din1 == '0);
            prem  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          work <= qmag;
          prem <= prem_nx;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'(LAST)) begin
            if (zdiv) begin
              dout_quot   <= '1;
              dout_rem    <= '0;
              div_by_zero <= 1'b1;
            end else begin
              dout_quot   <= qsgn;
              dout_rem    <= rsgn;
              div_by_zero <= 1'b0;
            end
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
